// File: rtl/inst_prefetch_queue_pkg.sv
// Shared types and constants for the instruction prefetch queue.
// Optional statistics outputs are enabled with the PREFETCH_STATS_EN macro.
package inst_prefetch_queue_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INST         = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
  } pf_entry_t;

endpackage

// File: rtl/inst_prefetch_queue_pf_fifo.sv
// In-order FIFO of {inst, pc} entries with synchronous clear; the head is read
// straight from the storage registers, so a push becomes visible one cycle later.
module pf_fifo
  import inst_prefetch_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   push,
  input  logic                   pop,
  input  pf_entry_t              push_data,
  output pf_entry_t              head,
  output logic                   head_valid,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  pf_entry_t       mem [DEPTH];
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  // Storage needs no reset: an entry is only ever read after it was written.
  always_ff @(posedge clk) begin
    if (push && !rst && !clear) mem[wr_ptr] <= push_data;
  end

  assign head       = mem[rd_ptr];
  assign head_valid = (count != '0);

endmodule

// File: rtl/inst_prefetch_queue.sv
// Instruction prefetch buffer: runs sequential fetches ahead of IF_ID, flushes on redirect.
// Define PREFETCH_STATS_EN to add saturating redirect / dropped-response counters.
module inst_prefetch_queue
  import inst_prefetch_queue_pkg::*;
#(
  parameter int               DEPTH    = 4,
  parameter int               WIDTH    = XLEN,
  parameter logic [WIDTH-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                   clk,
  input  logic                   start,
  output logic                   imem_req,
  output logic [WIDTH-1:0]       imem_addr,
  input  logic                   imem_ready,
  input  logic                   imem_rvalid,
  input  logic [WIDTH-1:0]       imem_rdata,
  input  logic                   redirect,
  input  logic [WIDTH-1:0]       redirect_pc,
  input  logic                   stall,
  output logic                   inst_valid,
  output logic [WIDTH-1:0]       inst_out,
  output logic [WIDTH-1:0]       curr_pc,
  output logic [WIDTH-1:0]       pc_plus4,
  output logic [$clog2(DEPTH):0] count
`ifdef PREFETCH_STATS_EN
  ,
  output logic [31:0]            stat_redirects,
  output logic [31:0]            stat_discards
`endif
);

  localparam int               CW      = $clog2(DEPTH) + 1;
  localparam logic [WIDTH-1:0] PC_STEP = WIDTH'(4);

  logic [WIDTH-1:0] fetch_pc;
  logic [WIDTH-1:0] rsp_pc;
  logic [WIDTH-1:0] last_pc;
  logic [CW-1:0]    outstanding;
  logic [CW-1:0]    discard;
  logic [CW:0]      inflight_total;
  pf_entry_t        head;
  pf_entry_t        push_data;
  logic             head_valid;
  logic             accept;
  logic             drop;
  logic             push;
  logic             pop;

  // imem handshake: a request transfers on any cycle with imem_req && imem_ready;
  // imem_addr is held while imem_req is high and not yet accepted. Responses
  // come back in request order, one per imem_rvalid, at least a cycle later.
  // Room is reserved for every in-flight request, so a response never meets a full queue.
  assign inflight_total = {1'b0, count} + {1'b0, outstanding};
  assign imem_req       = !start && !redirect && (inflight_total < (CW+1)'(DEPTH));
  assign imem_addr      = fetch_pc;
  assign accept         = imem_req && imem_ready;

  // Responses to requests issued before a redirect are dropped, including one landing with it.
  assign drop      = imem_rvalid && (redirect || (discard != '0));
  assign push      = imem_rvalid && !drop;
  assign pop       = head_valid && !stall && !redirect;
  assign push_data = '{inst: imem_rdata, pc: rsp_pc};

  pf_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (start),
    .clear      (redirect),
    .push       (push),
    .pop        (pop),
    .push_data  (push_data),
    .head       (head),
    .head_valid (head_valid),
    .count      (count)
  );

  always_ff @(posedge clk) begin
    if (start) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      last_pc     <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      if (head_valid) last_pc <= head.pc;
      if (redirect) begin
        fetch_pc <= redirect_pc;
        rsp_pc   <= redirect_pc;
      end else begin
        if (accept) fetch_pc <= fetch_pc + PC_STEP;
        if (push)   rsp_pc   <= rsp_pc + PC_STEP;
      end
      unique case ({accept, imem_rvalid})
        2'b10:   outstanding <= outstanding + CW'(1);
        2'b01:   outstanding <= outstanding - CW'(1);
        default: ;
      endcase
      // Everything still in flight at a redirect belongs to a dead stream.
      if (redirect)  discard <= outstanding - CW'(imem_rvalid);
      else if (drop) discard <= discard - CW'(1);
    end
  end

  assign inst_valid = head_valid;
  assign inst_out   = head_valid ? head.inst : NOP_INST;
  assign curr_pc    = head_valid ? head.pc : last_pc;
  assign pc_plus4   = curr_pc + PC_STEP;

`ifdef PREFETCH_STATS_EN
  always_ff @(posedge clk) begin
    if (start) begin
      stat_redirects <= '0;
      stat_discards  <= '0;
    end else begin
      if (redirect && (stat_redirects != '1)) stat_redirects <= stat_redirects + 32'd1;
      if (drop && (stat_discards != '1))      stat_discards  <= stat_discards + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_inst_prefetch_queue.sv
// Bench for inst_prefetch_queue: in-order memory model with epochs, a queue-level
// reference of the instruction stream, and a per-cycle compare process.
module tb_inst_prefetch_queue;

  localparam int          DEPTH  = 4;
  localparam int          W      = 32;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic         clk = 1'b0;
  logic         start, imem_req, imem_ready, imem_rvalid, redirect, stall, inst_valid;
  logic [W-1:0] imem_addr, imem_rdata, redirect_pc, inst_out, curr_pc, pc_plus4;
  logic [2:0]   count;
`ifdef PREFETCH_STATS_EN
  logic [31:0]  stat_redirects, stat_discards;
`endif

  always #5 clk = ~clk;

  inst_prefetch_queue dut (
    .clk         (clk),
    .start       (start),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .stall       (stall),
    .inst_valid  (inst_valid),
    .inst_out    (inst_out),
    .curr_pc     (curr_pc),
    .pc_plus4    (pc_plus4),
    .count       (count)
`ifdef PREFETCH_STATS_EN
    ,
    .stat_redirects (stat_redirects),
    .stat_discards  (stat_discards)
`endif
  );

  // Memory side: each accepted request remembers the fetch stream (epoch) it belongs to.
  typedef struct {
    logic [W-1:0] addr;
    int unsigned  epoch;
    int unsigned  due;
  } req_t;

  req_t         mem_q[$];
  logic [W-1:0] exp_q[$];   // PCs of instructions expected at IF_ID, head first
  logic [W-1:0] m_fetch, m_last;
  int unsigned  epoch, cyc;
  bit           model_on;
  int unsigned  p_ready = 100, p_rvalid = 100, lat_min = 1, lat_max = 1;
  int           n_checks, n_fail;
`ifdef PREFETCH_STATS_EN
  logic [31:0]  m_sr, m_sd;
`endif

  logic         s_valid, s_req;
  logic [W-1:0] s_inst, s_pc, s_pc4, s_addr;
  logic [2:0]   s_count;

  function automatic logic [W-1:0] inst_of(input logic [W-1:0] addr);
    return {addr[15:0], addr[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Reference model: advances at each rising edge from the inputs of the ending cycle.
  always @(posedge clk) begin
    req_t r;
    bit   req, drop;
    drop = 1'b0;
    r    = '{addr: '0, epoch: 0, due: 0};
    if (start) begin
      exp_q.delete();
      mem_q.delete();
      m_fetch  = RST_PC;
      m_last   = RST_PC;
      epoch++;
      model_on = 1'b1;
`ifdef PREFETCH_STATS_EN
      m_sr = '0;
      m_sd = '0;
`endif
    end else if (model_on) begin
      req = !redirect && (exp_q.size() + mem_q.size() < DEPTH);
      if (exp_q.size() > 0) m_last = exp_q[0];
      if (imem_rvalid) begin
        r    = mem_q.pop_front();
        drop = redirect || (r.epoch != epoch);
`ifdef PREFETCH_STATS_EN
        if (drop && m_sd != 32'hFFFF_FFFF) m_sd++;
`endif
      end
      if (redirect) begin
        exp_q.delete();
        epoch++;
        m_fetch = redirect_pc;
`ifdef PREFETCH_STATS_EN
        if (m_sr != 32'hFFFF_FFFF) m_sr++;
`endif
      end else begin
        if (exp_q.size() > 0 && !stall) void'(exp_q.pop_front());
        if (imem_rvalid && !drop) exp_q.push_back(r.addr);
        if (req && imem_ready) begin
          mem_q.push_back('{addr: m_fetch, epoch: epoch, due: cyc + $urandom_range(lat_max, lat_min)});
          m_fetch = m_fetch + 32'd4;
        end
      end
    end
    cyc++;
  end

  // Compare process: mid-cycle, all DUT outputs against the model.
  always @(negedge clk) begin
    bit           ev, ereq;
    logic [W-1:0] epc;
    s_valid = inst_valid;
    s_req   = imem_req;
    s_inst  = inst_out;
    s_pc    = curr_pc;
    s_pc4   = pc_plus4;
    s_addr  = imem_addr;
    s_count = count;
    if (model_on) begin
      ev   = (exp_q.size() > 0);
      epc  = ev ? exp_q[0] : m_last;
      ereq = !start && !redirect && (exp_q.size() + mem_q.size() < DEPTH);
      check("inst_valid", 32'(inst_valid), 32'(ev));
      check("inst_out", inst_out, ev ? inst_of(exp_q[0]) : NOP);
      check("curr_pc", curr_pc, epc);
      check("pc_plus4", pc_plus4, epc + 32'd4);
      check("count", 32'(count), 32'(exp_q.size()));
      check("imem_req", 32'(imem_req), 32'(ereq));
      check("imem_addr", imem_addr, m_fetch);
`ifdef PREFETCH_STATS_EN
      check("stat_redirects", stat_redirects, m_sr);
      check("stat_discards", stat_discards, m_sd);
`endif
    end
  end

  // Drives the memory side for one cycle; the caller sets start/stall/redirect.
  task automatic cycle();
    imem_ready = ($urandom_range(99, 0) < p_ready);
    if (!start && mem_q.size() > 0 && mem_q[0].due <= cyc && $urandom_range(99, 0) < p_rvalid) begin
      imem_rvalid = 1'b1;
      imem_rdata  = inst_of(mem_q[0].addr);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    start    = 1'b1;
    redirect = 1'b0;
    stall    = 1'b0;
    p_ready  = 100;
    p_rvalid = 100;
    lat_min  = 1;
    lat_max  = 1;
    cycle();
    cycle();
    start = 1'b0;
  endtask

  initial begin
    bit found;
    start = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;

    // Zero-wait memory right after reset.
    do_reset();
    for (int i = 1; i <= 6; i++) begin
      cycle();
      if (i == 1) begin
        check("rst_valid", 32'(s_valid), 32'd0);
        check("rst_count", 32'(s_count), 32'd0);
        check("rst_inst", s_inst, NOP);
        check("rst_pc", s_pc, RST_PC);
        check("rst_pc4", s_pc4, 32'h4);
        check("rst_addr", s_addr, RST_PC);
      end
      check("zw_valid", 32'(s_valid), (i >= 3) ? 32'd1 : 32'd0);
      if (i >= 3) check("zw_pc", s_pc, 32'(4 * (i - 3)));
      check("zw_count_le4", 32'(s_count <= 3'd4), 32'd1);
    end

    // Long stall fills the queue, then four back-to-back pops.
    do_reset();
    stall = 1'b1;
    repeat (10) cycle();
    check("stall_count", 32'(s_count), 32'd4);
    check("stall_req", 32'(s_req), 32'd0);
    check("stall_pc", s_pc, 32'h0);
    stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      check("drain_valid", 32'(s_valid), 32'd1);
      check("drain_pc", s_pc, 32'(4 * i));
    end

    // Latency 3, redirect with two requests in flight.
    do_reset();
    lat_min = 3;
    lat_max = 3;
    found   = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (mem_q.size() == 2) begin
        redirect = 1'b1; redirect_pc = 32'h100;
        cycle();
        redirect = 1'b0;
        found    = 1'b1;
      end else cycle();
    end
    check("c_redirect_hit", 32'(found), 32'd1);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      cycle();
      if (s_valid) found = 1'b1;
    end
    check("c_first_valid", 32'(found), 32'd1);
    check("c_pc", s_pc, 32'h100);
    check("c_pc4", s_pc4, 32'h104);
`ifdef PREFETCH_STATS_EN
    check("c_stat_redirects", stat_redirects, 32'd1);
    check("c_stat_discards", stat_discards, 32'd2);
`endif

    // Redirect coinciding with a response and stall.
    do_reset();
    stall = 1'b1;
    cycle();
    redirect = 1'b1; redirect_pc = 32'h100;
    cycle();
    redirect = 1'b0;
    check("d_req_in_redirect", 32'(s_req), 32'd0);
    cycle();
    check("d_valid", 32'(s_valid), 32'd0);
    check("d_count", 32'(s_count), 32'd0);
    check("d_req_after", 32'(s_req), 32'd1);
    check("d_addr", s_addr, 32'h100);
    stall = 1'b0;

    // Memory back-pressure for five cycles.
    do_reset();
    cycle();
    cycle();
    p_ready = 0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("e_addr_hold", s_addr, 32'h8);
      check("e_req_hold", 32'(s_req), 32'd1);
    end
    check("e_valid", 32'(s_valid), 32'd0);
    check("e_inst", s_inst, NOP);
    p_ready = 100;

    // Reset in the middle of a stream.
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      if (m_fetch == 32'h40) found = 1'b1;
      else cycle();
    end
    check("f_reach_40", 32'(found), 32'd1);
    start = 1'b1;
    cycle();
    start = 1'b0;
    cycle();
    check("f_valid", 32'(s_valid), 32'd0);
    check("f_count", 32'(s_count), 32'd0);
    check("f_addr", s_addr, RST_PC);
    check("f_req", 32'(s_req), 32'd1);
`ifdef PREFETCH_STATS_EN
    check("f_stat_redirects", stat_redirects, 32'd0);
    check("f_stat_discards", stat_discards, 32'd0);
`endif

    // Randomised traffic, including targets near the top of the address space.
    p_ready  = 70;
    p_rvalid = 80;
    lat_min  = 1;
    lat_max  = 4;
    for (int i = 0; i < 3000; i++) begin
      stall       = ($urandom_range(99, 0) < 30);
      redirect    = ($urandom_range(99, 0) < 6);
      redirect_pc = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(15, 0))) : $urandom;
      start       = ($urandom_range(199, 0) == 0);
      cycle();
    end
    start = 1'b0; redirect = 1'b0; stall = 1'b0;
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/inst_prefetch_queue.md
Name: inst_prefetch_queue

Overview:
- Instruction prefetch buffer between instruction memory and the Fetch stage / IF_ID register.
- Issues sequential word fetches ahead of the pipeline and buffers returned instructions with their PCs in an in-order queue.
- Presents one instruction per cycle to the IF_ID register; honours the hazard `stall`.
- On a taken branch (PC_Mux_Sel) it flushes, discards in-flight responses and refetches from the target.

Parameters:
- DEPTH, 4, queue entries and maximum outstanding memory requests (power of two, ≥2).
- WIDTH, 32, instruction and address width.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  input  1  clock, all state on rising edge
- start  input  1  reset, synchronous, active-high
- imem_req  output  1  request valid to instruction memory
- imem_addr  output  WIDTH  request word address
- imem_ready  input  1  memory accepts request this cycle
- imem_rvalid  input  1  response valid (in order, latency ≥1)
- imem_rdata  input  WIDTH  response instruction
- redirect  input  1  taken branch (PC_Mux_Sel)
- redirect_pc  input  WIDTH  branch target (immAddress)
- stall  input  1  hazard stall from decode; hold head
- inst_valid  output  1  head entry valid
- inst_out  output  WIDTH  head instruction
- curr_pc  output  WIDTH  PC of head instruction
- pc_plus4  output  WIDTH  curr_pc + 4
- count  output  $clog2(DEPTH)+1  occupied entries

Behaviour:
- Reset (start=1 at edge):
  - fetch_pc=RESET_PC, rsp_pc=RESET_PC.
  - Queue empty; outstanding=0; discard=0.
  - Outputs: inst_valid=0, count=0, inst_out=32'h0000_0013 (NOP), curr_pc=RESET_PC, pc_plus4=RESET_PC+4.
  - imem_req=0 while start=1.
  - Reset mid-burst: pending responses are not tracked. The memory model must drop its responses on start.
- Issue:
  - imem_req = !start && !redirect && (count + outstanding < DEPTH).
  - imem_addr = fetch_pc.
  - Handshake imem_req && imem_ready: fetch_pc += 4 and outstanding += 1.
  - imem_addr is held stable while imem_req=1 and imem_ready=0.
- Response:
  - Every imem_rvalid decrements outstanding; an accept in the same cycle nets 0.
  - If discard>0: the response is dropped and discard -= 1.
  - Otherwise it is pushed as {imem_rdata, rsp_pc} and rsp_pc += 4.
  - The issue gating guarantees room, so a push never finds the queue full, even with no pop.
- Output:
  - Head is registered. A response pushed at edge N is visible from cycle N+1.
  - There is no bypass; minimum memory-to-IF_ID latency is 1 cycle after rvalid.
  - Pop when inst_valid && !stall.
  - Push and pop in the same cycle leave count unchanged.
  - Empty queue: inst_valid=0, inst_out=NOP, curr_pc/pc_plus4 hold their last values.
- Redirect (one-cycle pulse, highest priority over stall, push and pop):
  - Queue cleared; count=0.
  - fetch_pc=redirect_pc, rsp_pc=redirect_pc.
  - discard = outstanding − (imem_rvalid ? 1 : 0). The response arriving in the redirect cycle is dropped.
  - No request is issued in the redirect cycle.
  - First request to redirect_pc is issued the next cycle.
  - A redirect while discard>0 adds the new outstanding count; nothing from the old stream ever reaches the output.
- Arithmetic:
  - PCs wrap modulo 2^WIDTH.
  - Address bits [1:0] are passed through unchanged; misaligned targets are not checked.
- No state machine beyond the counters. Implicit states are IDLE (reset), STREAM and DRAIN (discard>0).

Optional Feature:
- Macro: PREFETCH_STATS_EN.
- When defined:
  - Extra outputs stat_redirects[31:0] and stat_discards[31:0].
  - They count redirect pulses and dropped responses, saturating at 32'hFFFF_FFFF.
  - Both are cleared by start.
- When undefined: the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Shared package holds:
  - NOP_INST = 32'h0000_0013.
  - RESET_PC default.
  - Typedef pf_entry_t {inst, pc}.
- One natural sub-module: pf_fifo (sync FIFO of pf_entry_t with push/pop/clear and registered head), instantiated once.

Test Plan:
- Zero-wait memory (ready=1, rvalid 1 cycle after accept), stall=0, after start drops → inst_out stream at PCs 0x0, 0x4, 0x8…; inst_valid=1 from cycle 3 onward; count ≤ 4.
- stall=1 held 10 cycles with DEPTH=4 → count saturates at 4, imem_req=0, head at curr_pc=0x0 unchanged; release → 0x0, 0x4, 0x8, 0xC popped on consecutive cycles.
- Memory latency 3, redirect pulse to 0x100 with 2 outstanding → next 2 responses dropped (discard 2→0); first inst_valid has curr_pc=0x100, pc_plus4=0x104.
- Redirect in the same cycle as imem_rvalid and stall=1 → queue empty next cycle, the rvalid data never appears, imem_req=0 that cycle, imem_addr=0x100 the following cycle.
- imem_ready=0 for 5 cycles with imem_req high → imem_addr stable at 0x8, outstanding unchanged, inst_valid drops to 0 once the queue drains, inst_out=0x00000013.
- start asserted mid-stream at fetch_pc=0x40 → next cycle inst_valid=0, count=0, imem_addr=RESET_PC once start=0; with PREFETCH_STATS_EN, after 3 redirects and 5 drops the stats read 3 and 5, then 0 after start.
